// File: rtl/bcd_xs3_serializer.sv
// BCD word to excess-3 serializer: accepts an NDIG-digit BCD word, rejects non-decimal
// digits, and emits digit+3 bit-serially (LSB first) plus the assembled parallel word.
module bcd_xs3_serializer #(
  parameter int NDIG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_bcd,
  output logic              ser_valid,
  output logic              ser_out,
  output logic              ser_first,
  output logic              ser_last,
  output logic              par_valid,
  output logic [4*NDIG-1:0] par_xs3,
  output logic              err
);

  localparam int W  = 4 * NDIG;
  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // True when every nibble of the word is a decimal digit (0..9).
  function automatic logic digits_ok(input logic [W-1:0] w);
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < NDIG; d++) begin
      if (w[4*d +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  state_t          state_q, state_d;
  logic [W-1:0]    word_q, word_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            in_ready_q, in_ready_d;
  logic            ser_valid_q, ser_valid_d;
  logic            ser_out_q, ser_out_d;
  logic            ser_first_q, ser_first_d;
  logic            ser_last_q, ser_last_d;
  logic            par_valid_q, par_valid_d;
  logic [W-1:0]    par_xs3_q, par_xs3_d;
  logic            err_q, err_d;

  logic [IW-1:0]   nxt_idx_s;
  logic            b_s, k_s, c_s, sum_s;

  // Next-state and output computation; bit i of the stream is prepared one edge ahead.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    in_ready_d  = in_ready_q;
    ser_valid_d = 1'b0;
    ser_out_d   = 1'b0;
    ser_first_d = 1'b0;
    ser_last_d  = 1'b0;
    par_valid_d = 1'b0;
    par_xs3_d   = par_xs3_q;
    err_d       = 1'b0;

    // Constant 4'b0011 contributes a 1 on the two low bits of each digit.
    nxt_idx_s = idx_q + {{(IW-1){1'b0}}, 1'b1};
    b_s       = word_q[nxt_idx_s];
    k_s       = ~nxt_idx_s[1];
    c_s       = (nxt_idx_s[1:0] == 2'b00) ? 1'b0 : carry_q;
    sum_s     = b_s ^ k_s ^ c_s;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          if (digits_ok(in_bcd)) begin
            state_d     = SHIFT;
            word_d      = in_bcd;
            idx_d       = '0;
            ser_valid_d = 1'b1;
            ser_first_d = 1'b1;
            ser_out_d   = ~in_bcd[0];
            carry_d     = in_bcd[0];
            acc_d       = {{(W-1){1'b0}}, ~in_bcd[0]};
            in_ready_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          in_ready_d = 1'b1;
        end
      end
      SHIFT: begin
        if (idx_q == LAST_IDX) begin
          state_d     = IDLE;
          idx_d       = '0;
          carry_d     = 1'b0;
          par_valid_d = 1'b1;
          par_xs3_d   = acc_q;
          in_ready_d  = 1'b1;
        end else begin
          idx_d            = nxt_idx_s;
          ser_valid_d      = 1'b1;
          ser_out_d        = sum_s;
          ser_last_d       = (nxt_idx_s == LAST_IDX);
          carry_d          = (b_s & k_s) | (b_s & c_s) | (k_s & c_s);
          acc_d[nxt_idx_s] = sum_s;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      ser_valid_q <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
      par_valid_q <= 1'b0;
      par_xs3_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      ser_valid_q <= ser_valid_d;
      ser_out_q   <= ser_out_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
      par_valid_q <= par_valid_d;
      par_xs3_q   <= par_xs3_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign ser_valid = ser_valid_q;
  assign ser_out   = ser_out_q;
  assign ser_first = ser_first_q;
  assign ser_last  = ser_last_q;
  assign par_valid = par_valid_q;
  assign par_xs3   = par_xs3_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_xs3_serializer.sv
// Directed bench for bcd_xs3_serializer (NDIG=2) with hand-computed excess-3 results.
module tb_bcd_xs3_serializer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_bcd;
  logic       ser_valid;
  logic       ser_out;
  logic       ser_first;
  logic       ser_last;
  logic       par_valid;
  logic [7:0] par_xs3;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_xs3_serializer #(.NDIG(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .ser_valid (ser_valid),
    .ser_out   (ser_out),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .par_valid (par_valid),
    .par_xs3   (par_xs3),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in cycle T+1 of an accepted word; checks W serial bits then the parallel result.
  // exp_par bits double as the expected serial stream (LSB first).
  task automatic check_frame(input string name, input logic [7:0] exp_par, input bit inject);
    logic [7:0] e;
    e = exp_par;
    for (int i = 0; i < 8; i++) begin
      chk({name, " ser_valid"}, 32'(ser_valid), 32'd1);
      chk({name, " ser_out"},   32'(ser_out),   32'(e[i]));
      chk({name, " ser_first"}, 32'(ser_first), 32'(i == 0));
      chk({name, " ser_last"},  32'(ser_last),  32'(i == 7));
      chk({name, " in_ready"},  32'(in_ready),  32'd0);
      chk({name, " par_valid"}, 32'(par_valid), 32'd0);
      chk({name, " err"},       32'(err),       32'd0);
      if (inject && i == 3) begin
        in_valid = 1'b1;
        in_bcd   = 8'hFF;
      end else if (inject && i == 4) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk({name, " par_valid"}, 32'(par_valid), 32'd1);
    chk({name, " par_xs3"},   32'(par_xs3),   32'(exp_par));
    chk({name, " idle gap"},  32'(ser_valid), 32'd0);
    chk({name, " in_ready"},  32'(in_ready),  32'd1);
    chk({name, " err"},       32'(err),       32'd0);
  endtask

  // Drive one word for one accept edge, then check its frame.
  task automatic send(input string name, input logic [7:0] w, input logic [7:0] exp_par,
                      input bit inject);
    in_valid = 1'b1;
    in_bcd   = w;
    @(negedge clk);
    in_valid = 1'b0;
    in_bcd   = 8'h00;
    check_frame(name, exp_par, inject);
    @(negedge clk);
    chk({name, " par pulse"}, 32'(par_valid), 32'd0);
    chk({name, " par hold"},  32'(par_xs3),   32'(exp_par));
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bcd   = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst in_ready",  32'(in_ready),  32'd1);
    chk("rst ser_valid", 32'(ser_valid), 32'd0);
    chk("rst par_xs3",   32'(par_xs3),   32'd0);
    chk("rst err",       32'(err),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send("w59", 8'h59, 8'h8C, 1'b0);
    send("w00", 8'h00, 8'h33, 1'b0);
    send("w99", 8'h99, 8'hCC, 1'b0);

    // Rejected word: err pulse only.
    in_valid = 1'b1;
    in_bcd   = 8'h1A;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rej err",       32'(err),       32'd1);
    chk("rej ser_valid", 32'(ser_valid), 32'd0);
    chk("rej in_ready",  32'(in_ready),  32'd1);
    chk("rej par_valid", 32'(par_valid), 32'd0);
    @(negedge clk);
    chk("rej err pulse", 32'(err),       32'd0);
    chk("rej no ser",    32'(ser_valid), 32'd0);
    chk("rej par hold",  32'(par_xs3),   32'hCC);
    send("w27", 8'h27, 8'h5A, 1'b0);

    // Back-to-back with in_valid held high.
    in_valid = 1'b1;
    in_bcd   = 8'h12;
    @(negedge clk);
    in_bcd = 8'h34;
    check_frame("w12", 8'h45, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check_frame("w34", 8'h67, 1'b0);
    @(negedge clk);

    // Reset at bit index 3 of 8'h88.
    in_valid = 1'b1;
    in_bcd   = 8'h88;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort pre ser_valid", 32'(ser_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort ser_valid", 32'(ser_valid), 32'd0);
    chk("abort par_xs3",   32'(par_xs3),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort no par", 32'(par_valid), 32'd0);
      chk("abort no err", 32'(err),       32'd0);
      chk("abort no ser", 32'(ser_valid), 32'd0);
    end
    send("w05", 8'h05, 8'h38, 1'b0);

    // FF pulsed during SHIFT is ignored.
    send("w88", 8'h88, 8'hBB, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("inject err", 32'(err),       32'd0);
      chk("inject ser", 32'(ser_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
